decode_stage: RTL and testbench

- N-wide registered decode stage between fetch and issue; generalises the fixed two-slot combinational decoder to ISSUE_WIDTH slots.
- Adds a valid/ready handshake with a one-entry skid buffer, masks slots younger than the oldest predicted-taken slot, and detects non-branches predicted taken.
- For a non-branch predicted taken, emits a registered one-cycle redirect to that slot's PC+4, not its own PC.
- Sits after the fetch/predict stage; feeds the issue/dispatch stage.

---
 rtl/decode_stage_pkg.sv | 35 +++
 rtl/decode_stage_decoder.sv | 27 ++
 rtl/decode_stage_mask.sv | 47 ++++
 rtl/decode_stage.sv | 244 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared control-word layout and opcodes for decode_stage
// Contents: CTRL_W (per-slot control word width), control bit indices,
//           RV32 base opcode enum, is_branch() helper.
package decode_stage_pkg;

    localparam int CTRL_W = 8;

    // Bit positions inside one slot's control word
    localparam int COND_BRANCH = 0;
    localparam int JAL         = 1;
    localparam int JALR        = 2;
    localparam int LOAD        = 3;
    localparam int STORE       = 4;
    localparam int ALU_IMM     = 5;
    localparam int ALU_REG     = 6;
    localparam int UPPER_IMM   = 7;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    // Any control-flow instruction that may legitimately be predicted taken
    function automatic logic is_branch(input logic [CTRL_W-1:0] ctrl);
        return ctrl[COND_BRANCH] | ctrl[JAL] | ctrl[JALR];
    endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// rtl/decode_stage_decoder.sv - single-slot opcode decoder producing a control word
// Ports:
//   opcode_i  in   7       instruction opcode field (inst[6:0])
//   ctrl_o    out  CTRL_W  one-hot-ish control word, all zero for unknown opcodes
module decoder
    import decode_stage_pkg::*;
(
    input  logic [6:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OPC_BRANCH:         ctrl_o[COND_BRANCH] = 1'b1;
            OPC_JAL:            ctrl_o[JAL]         = 1'b1;
            OPC_JALR:           ctrl_o[JALR]        = 1'b1;
            OPC_LOAD:           ctrl_o[LOAD]        = 1'b1;
            OPC_STORE:          ctrl_o[STORE]       = 1'b1;
            OPC_OP_IMM:         ctrl_o[ALU_IMM]     = 1'b1;
            OPC_OP:             ctrl_o[ALU_REG]     = 1'b1;
            OPC_LUI, OPC_AUIPC: ctrl_o[UPPER_IMM]   = 1'b1;
            default:            ctrl_o              = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_mask.sv
// rtl/decode_stage_mask.sv - slot masking and non-branch-predicted-taken detection
// Ports:
//   slot_valid_i  in   ISSUE_WIDTH  raw per-slot valid
//   pred_taken_i  in   ISSUE_WIDTH  raw per-slot predicted-taken
//   is_br_i       in   ISSUE_WIDTH  slot decodes as a control-flow instruction
//   slot_valid_o  out  ISSUE_WIDTH  valid with slots younger than the first taken slot killed
//   pred_taken_o  out  ISSUE_WIDTH  surviving predicted-taken (cleared for non-branches)
//   wb_o          out  ISSUE_WIDTH  one-hot: slot predicted taken but not a branch
//   any_valid_o   out  1            at least one slot survives masking
//   wb_any_o      out  1            a redirect is required
module decode_mask #(
    parameter int ISSUE_WIDTH = 2
) (
    input  logic [ISSUE_WIDTH-1:0] slot_valid_i,
    input  logic [ISSUE_WIDTH-1:0] pred_taken_i,
    input  logic [ISSUE_WIDTH-1:0] is_br_i,
    output logic [ISSUE_WIDTH-1:0] slot_valid_o,
    output logic [ISSUE_WIDTH-1:0] pred_taken_o,
    output logic [ISSUE_WIDTH-1:0] wb_o,
    output logic                   any_valid_o,
    output logic                   wb_any_o
);

    logic [ISSUE_WIDTH-1:0] v;
    logic [ISSUE_WIDTH-1:0] pt;
    logic                   blocked;

    // Walk from oldest to youngest; once a valid taken slot is seen every
    // younger slot is on the wrong path. This also leaves at most one pt bit.
    always_comb begin
        v       = '0;
        pt      = '0;
        blocked = 1'b0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            v[k]    = slot_valid_i[k] && !blocked;
            pt[k]   = v[k] && pred_taken_i[k];
            blocked = blocked | pt[k];
        end
    end

    assign wb_o         = pt & ~is_br_i;
    assign pred_taken_o = pt & is_br_i;
    assign slot_valid_o = v;
    assign any_valid_o  = |v;
    assign wb_any_o     = |wb_o;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - N-wide registered decode stage with skid buffer and redirect
// Optional feature macro: DECODE_PERF_EN (adds redirect / stall counters).
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   in_valid_i / in_ready_o          fetch-side handshake
//   inst_i, pc_i                     ISSUE_WIDTH*XLEN, slot k at [k*XLEN +: XLEN]
//   slot_valid_i, pred_taken_i       ISSUE_WIDTH per-slot flags
//   out_valid_o / out_ready_i        issue-side handshake
//   inst_o, pc_o, ctrl_o             registered bundle and per-slot control words
//   slot_valid_o, pred_taken_o       masked flags
//   redirect_o, redirect_pc_o        one-cycle redirect pulse and its target
//   perf_redirect_cnt_o, perf_stall_cnt_o  (DECODE_PERF_EN only)
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int XLEN        = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ISSUE_WIDTH*XLEN-1:0]   inst_i,
    input  logic [ISSUE_WIDTH*XLEN-1:0]   pc_i,
    input  logic [ISSUE_WIDTH-1:0]        slot_valid_i,
    input  logic [ISSUE_WIDTH-1:0]        pred_taken_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ISSUE_WIDTH*XLEN-1:0]   inst_o,
    output logic [ISSUE_WIDTH*XLEN-1:0]   pc_o,
    output logic [ISSUE_WIDTH*CTRL_W-1:0] ctrl_o,
    output logic [ISSUE_WIDTH-1:0]        slot_valid_o,
    output logic [ISSUE_WIDTH-1:0]        pred_taken_o,
    output logic                          redirect_o,
    output logic [XLEN-1:0]               redirect_pc_o
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]                   perf_redirect_cnt_o,
    output logic [31:0]                   perf_stall_cnt_o
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // ---------------- per-slot decode and masking ----------------
    logic [ISSUE_WIDTH*CTRL_W-1:0] ctrl_in;
    logic [ISSUE_WIDTH-1:0]        is_br;
    logic [ISSUE_WIDTH-1:0]        v_in;
    logic [ISSUE_WIDTH-1:0]        pt_in;
    logic [ISSUE_WIDTH-1:0]        wb;
    logic                          any_valid;
    logic                          wb_any;

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_slot
        decoder u_dec (
            .opcode_i (inst_i[g*XLEN +: 7]),
            .ctrl_o   (ctrl_in[g*CTRL_W +: CTRL_W])
        );
        assign is_br[g] = is_branch(ctrl_in[g*CTRL_W +: CTRL_W]);
    end

    decode_mask #(.ISSUE_WIDTH(ISSUE_WIDTH)) u_mask (
        .slot_valid_i (slot_valid_i),
        .pred_taken_i (pred_taken_i),
        .is_br_i      (is_br),
        .slot_valid_o (v_in),
        .pred_taken_o (pt_in),
        .wb_o         (wb),
        .any_valid_o  (any_valid),
        .wb_any_o     (wb_any)
    );

    // wb is one-hot, so OR-ing the gated PCs selects the offending slot
    logic [XLEN-1:0] sel_pc;
    always_comb begin
        sel_pc = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (wb[k]) begin
                sel_pc = sel_pc | pc_i[k*XLEN +: XLEN];
            end
        end
    end

    // ---------------- OUT / SKID registers ----------------
    logic                          out_valid_q,  out_valid_d;
    logic [ISSUE_WIDTH*XLEN-1:0]   out_inst_q,   out_inst_d;
    logic [ISSUE_WIDTH*XLEN-1:0]   out_pc_q,     out_pc_d;
    logic [ISSUE_WIDTH*CTRL_W-1:0] out_ctrl_q,   out_ctrl_d;
    logic [ISSUE_WIDTH-1:0]        out_sv_q,     out_sv_d;
    logic [ISSUE_WIDTH-1:0]        out_pt_q,     out_pt_d;
    logic                          skid_valid_q, skid_valid_d;
    logic [ISSUE_WIDTH*XLEN-1:0]   skid_inst_q,  skid_inst_d;
    logic [ISSUE_WIDTH*XLEN-1:0]   skid_pc_q,    skid_pc_d;
    logic [ISSUE_WIDTH*CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [ISSUE_WIDTH-1:0]        skid_sv_q,    skid_sv_d;
    logic [ISSUE_WIDTH-1:0]        skid_pt_q,    skid_pt_d;
    logic                          in_ready_q,   in_ready_d;
    logic                          redirect_q,   redirect_d;
    logic [XLEN-1:0]               redir_pc_q,   redir_pc_d;

    logic accept;
    logic enq;
    logic drain;

    assign accept = in_valid_i && in_ready_q && !flush_i;
    // Bundles with no surviving slot are consumed but never occupy a register
    assign enq    = accept && any_valid;
    assign drain  = out_valid_q && out_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_ctrl_d   = out_ctrl_q;
        out_sv_d     = out_sv_q;
        out_pt_d     = out_pt_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_sv_d    = skid_sv_q;
        skid_pt_d    = skid_pt_q;
        redir_pc_d   = redir_pc_q;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            // OUT is free this cycle: older SKID contents take priority
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_pc_d     = skid_pc_q;
                out_ctrl_d   = skid_ctrl_q;
                out_sv_d     = skid_sv_q;
                out_pt_d     = skid_pt_q;
                skid_valid_d = 1'b0;
            end else if (enq) begin
                out_valid_d  = 1'b1;
                out_inst_d   = inst_i;
                out_pc_d     = pc_i;
                out_ctrl_d   = ctrl_in;
                out_sv_d     = v_in;
                out_pt_d     = pt_in;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (enq) begin
            // OUT is stalled; park the new bundle
            skid_valid_d = 1'b1;
            skid_inst_d  = inst_i;
            skid_pc_d    = pc_i;
            skid_ctrl_d  = ctrl_in;
            skid_sv_d    = v_in;
            skid_pt_d    = pt_in;
        end

        in_ready_d = !skid_valid_d;

        // accept already excludes flush, so a flush-cycle bundle cannot redirect
        redirect_d = accept && wb_any;
        if (redirect_d) begin
            redir_pc_d = sel_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_ctrl_q   <= '0;
            out_sv_q     <= '0;
            out_pt_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_ctrl_q  <= '0;
            skid_sv_q    <= '0;
            skid_pt_q    <= '0;
            in_ready_q   <= 1'b1;
            redirect_q   <= 1'b0;
            redir_pc_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_ctrl_q   <= out_ctrl_d;
            out_sv_q     <= out_sv_d;
            out_pt_q     <= out_pt_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_sv_q    <= skid_sv_d;
            skid_pt_q    <= skid_pt_d;
            in_ready_q   <= in_ready_d;
            redirect_q   <= redirect_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign inst_o        = out_inst_q;
    assign pc_o          = out_pc_q;
    assign ctrl_o        = out_ctrl_q;
    assign slot_valid_o  = out_sv_q;
    assign pred_taken_o  = out_pt_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redir_pc_q;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_redirect_q, perf_redirect_d;
    logic [31:0] perf_stall_q,    perf_stall_d;

    // Free-running event counters; flush deliberately does not touch them
    always_comb begin
        perf_redirect_d = perf_redirect_q;
        perf_stall_d    = perf_stall_q;
        if (redirect_q) begin
            perf_redirect_d = perf_redirect_q + 32'd1;
        end
        if (out_valid_q && !out_ready_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_redirect_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            perf_redirect_q <= perf_redirect_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_redirect_cnt_o = perf_redirect_q;
    assign perf_stall_cnt_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int W  = 2;
    localparam int XL = 32;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] JALI = 32'h0080006f;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [W*XL-1:0]       inst_i;
    logic [W*XL-1:0]       pc_i;
    logic [W-1:0]          slot_valid_i;
    logic [W-1:0]          pred_taken_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [W*XL-1:0]       inst_o;
    logic [W*XL-1:0]       pc_o;
    logic [W*CTRL_W-1:0]   ctrl_o;
    logic [W-1:0]          slot_valid_o;
    logic [W-1:0]          pred_taken_o;
    logic                  redirect_o;
    logic [XL-1:0]         redirect_pc_o;
`ifdef DECODE_PERF_EN
    logic [31:0]           perf_redirect_cnt_o;
    logic [31:0]           perf_stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    decode_stage #(.ISSUE_WIDTH(W), .XLEN(XL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .inst_i        (inst_i),
        .pc_i          (pc_i),
        .slot_valid_i  (slot_valid_i),
        .pred_taken_i  (pred_taken_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .ctrl_o        (ctrl_o),
        .slot_valid_o  (slot_valid_o),
        .pred_taken_o  (pred_taken_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o)
`ifdef DECODE_PERF_EN
        ,
        .perf_redirect_cnt_o (perf_redirect_cnt_o),
        .perf_stall_cnt_o    (perf_stall_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W*XL-1:0] inst;
        logic [W*XL-1:0] pc;
        logic [W-1:0]    sv;
        logic [W-1:0]    pt;
    } bundle_t;

    bundle_t       mq[$];      // bundles held by the stage, oldest first (capacity 2)
    logic          m_redir;
    logic [XL-1:0] m_rpc;

    function automatic logic [CTRL_W-1:0] ref_ctrl(input logic [XL-1:0] ins);
        logic [CTRL_W-1:0] r;
        r = '0;
        case (ins[6:0])
            7'h63:        r[COND_BRANCH] = 1'b1;
            7'h6f:        r[JAL]         = 1'b1;
            7'h67:        r[JALR]        = 1'b1;
            7'h03:        r[LOAD]        = 1'b1;
            7'h23:        r[STORE]       = 1'b1;
            7'h13:        r[ALU_IMM]     = 1'b1;
            7'h33:        r[ALU_REG]     = 1'b1;
            7'h37, 7'h17: r[UPPER_IMM]   = 1'b1;
            default:      r              = '0;
        endcase
        return r;
    endfunction

    function automatic logic [W*CTRL_W-1:0] ref_ctrl_bus(input logic [W*XL-1:0] ins);
        logic [W*CTRL_W-1:0] r;
        for (int k = 0; k < W; k++) r[k*CTRL_W +: CTRL_W] = ref_ctrl(ins[k*XL +: XL]);
        return r;
    endfunction

    // Oldest valid taken slot ends the bundle; a non-branch there needs a redirect
    task automatic ref_mask(input logic [W-1:0] sv, input logic [W-1:0] pt,
                            input logic [W*XL-1:0] ins,
                            output logic [W-1:0] v, output logic [W-1:0] pto,
                            output int wbk);
        int first;
        logic [6:0] op;
        first = W;
        for (int k = W - 1; k >= 0; k--) if (sv[k] && pt[k]) first = k;
        v   = '0;
        pto = '0;
        wbk = -1;
        for (int k = 0; k < W; k++) v[k] = sv[k] && (k <= first);
        if (first < W) begin
            op = ins[first*XL +: 7];
            if (op == 7'h63 || op == 7'h6f || op == 7'h67) pto[first] = 1'b1;
            else wbk = first;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_redir = 1'b0;
        m_rpc   = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] v, pto;
        int           wbk;
        bit           acc;
        bundle_t      b;
        ref_mask(slot_valid_i, pred_taken_i, inst_i, v, pto, wbk);
        acc = in_valid_i && !flush_i && (mq.size() < 2);
        if (flush_i) begin
            mq.delete();
            m_redir = 1'b0;
        end else begin
            if (mq.size() > 0 && out_ready_i) mq.delete(0);
            if (acc && v != '0) begin
                b.inst = inst_i;
                b.pc   = pc_i;
                b.sv   = v;
                b.pt   = pto;
                mq.push_back(b);
            end
            m_redir = acc && (wbk >= 0);
            if (m_redir) m_rpc = pc_i[wbk*XL +: XL] + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] i0, input logic [31:0] p0,
                          input logic [31:0] i1, input logic [31:0] p1,
                          input logic [1:0] sv, input logic [1:0] pt);
        in_valid_i   = v;
        inst_i       = {i1, i0};
        pc_i         = {p1, p0};
        slot_valid_i = sv;
        pred_taken_i = pt;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        set_in(1'b0, 0, 0, 0, 0, 2'b00, 2'b00);
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL reset_redirect: got %b want 0", redirect_o); end
        n_cmp++; if (redirect_pc_o !== '0) begin n_bad++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc_o); end
        n_cmp++; if ({inst_o, pc_o, ctrl_o, slot_valid_o, pred_taken_o} !== '0) begin n_bad++; $display("FAIL reset_data: got inst %h pc %h ctrl %h want all 0", inst_o, pc_o, ctrl_o); end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        set_in(1'b1, ADDI, 32'h100, BEQ, 32'h104, 2'b11, 2'b00);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid: got %b want 1", out_valid_o); end
        n_cmp++; if (slot_valid_o !== 2'b11) begin n_bad++; $display("FAIL basic_slot_valid: got %b want 11", slot_valid_o); end
        n_cmp++; if (ctrl_o[CTRL_W+COND_BRANCH] !== 1'b1) begin n_bad++; $display("FAIL basic_cond_branch: got %b want 1", ctrl_o[CTRL_W+COND_BRANCH]); end
        n_cmp++; if (ctrl_o !== ref_ctrl_bus({BEQ, ADDI})) begin n_bad++; $display("FAIL basic_ctrl: got %h want %h", ctrl_o, ref_ctrl_bus({BEQ, ADDI})); end
        n_cmp++; if (pc_o !== {32'h104, 32'h100}) begin n_bad++; $display("FAIL basic_pc: got %h want 0000010400000100", pc_o); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL basic_redirect: got %b want 0", redirect_o); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL basic_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_wasnt_branch();
        set_in(1'b1, ADDI, 32'h200, ADDI, 32'h204, 2'b11, 2'b01);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (slot_valid_o !== 2'b01) begin n_bad++; $display("FAIL wb_slot_valid: got %b want 01", slot_valid_o); end
        n_cmp++; if (pred_taken_o !== 2'b00) begin n_bad++; $display("FAIL wb_pred_taken: got %b want 00", pred_taken_o); end
        n_cmp++; if (redirect_o !== 1'b1) begin n_bad++; $display("FAIL wb_redirect: got %b want 1", redirect_o); end
        n_cmp++; if (redirect_pc_o !== 32'h204) begin n_bad++; $display("FAIL wb_redirect_pc: got %h want 00000204", redirect_pc_o); end
        tick();
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL wb_redirect_pulse: got %b want 0", redirect_o); end
        n_cmp++; if (redirect_pc_o !== 32'h204) begin n_bad++; $display("FAIL wb_redirect_pc_hold: got %h want 00000204", redirect_pc_o); end
        // pc+4 wraps at the top of the address space
        set_in(1'b1, ADDI, 32'hffff_fffc, ADDI, 32'h0, 2'b01, 2'b01);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (redirect_pc_o !== 32'h0) begin n_bad++; $display("FAIL wb_redirect_wrap: got %h want 00000000", redirect_pc_o); end
        tick();
    endtask

    task automatic test_jal_taken();
        set_in(1'b1, JALI, 32'h300, BEQ, 32'h304, 2'b11, 2'b11);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (slot_valid_o !== 2'b01) begin n_bad++; $display("FAIL jal_slot_valid: got %b want 01", slot_valid_o); end
        n_cmp++; if (pred_taken_o !== 2'b01) begin n_bad++; $display("FAIL jal_pred_taken: got %b want 01", pred_taken_o); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL jal_redirect: got %b want 0", redirect_o); end
        tick();
        // empty bundle: consumed, never shown
        set_in(1'b1, ADDI, 32'h340, ADDI, 32'h344, 2'b00, 2'b11);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_out_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL empty_redirect: got %b want 0", redirect_o); end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b0;
        set_in(1'b1, ADDI, 32'h400, ADDI, 32'h404, 2'b11, 2'b00);
        tick();
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a: got %b want 1", in_ready_o); end
        set_in(1'b1, ADDI, 32'h500, ADDI, 32'h504, 2'b11, 2'b00);
        tick();
        in_valid_i = 1'b0;
        n_cmp++; if (pc_o !== {32'h404, 32'h400}) begin n_bad++; $display("FAIL bp_hold_a: got %h want A", pc_o); end
        n_cmp++; if (in_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low: got %b want 0", in_ready_o); end
        tick();
        n_cmp++; if (pc_o !== {32'h404, 32'h400} || out_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_stall_hold: got pc %h valid %b want A 1", pc_o, out_valid_o); end
        out_ready_i = 1'b1;
        tick();
        n_cmp++; if (pc_o !== {32'h504, 32'h500} || out_valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_b_out: got pc %h valid %b want B 1", pc_o, out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b want 1", in_ready_o); end
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        set_in(1'b1, ADDI, 32'h600, ADDI, 32'h604, 2'b11, 2'b00);
        tick();
        set_in(1'b1, ADDI, 32'h700, ADDI, 32'h704, 2'b11, 2'b00);
        tick();
        set_in(1'b1, ADDI, 32'h800, ADDI, 32'h804, 2'b11, 2'b01);
        flush_i = 1'b1;
        tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid_o); end
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready_o); end
        n_cmp++; if (redirect_o !== 1'b0) begin n_bad++; $display("FAIL flush_redirect: got %b want 0", redirect_o); end
        // stage ready, wasnt-branch bundle in flush cycle: dropped, no redirect
        tick();
        n_cmp++; if (redirect_o !== 1'b0 || out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_suppress: got redirect %b valid %b want 0 0", redirect_o, out_valid_o); end
        // redirect already on the wire completes its cycle despite flush
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        flush_i = 1'b1;
        #1;
        n_cmp++; if (redirect_o !== 1'b1) begin n_bad++; $display("FAIL flush_inflight_redirect: got %b want 1", redirect_o); end
        tick();
        flush_i = 1'b0;
        n_cmp++; if (redirect_o !== 1'b0 || out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_after_inflight: got redirect %b valid %b want 0 0", redirect_o, out_valid_o); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        set_in(1'b1, ADDI, 32'h900, ADDI, 32'h904, 2'b11, 2'b01);
        tick();
        in_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++; if (out_valid_o !== 1'b0 || redirect_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid_redirect: got %b %b want 0 0", out_valid_o, redirect_o); end
        n_cmp++; if (redirect_pc_o !== '0 || pc_o !== '0 || slot_valid_o !== '0) begin n_bad++; $display("FAIL rstmid_data: got rpc %h pc %h want 0", redirect_pc_o, pc_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready_o); end
`ifdef DECODE_PERF_EN
        set_in(1'b1, ADDI, 32'ha00, ADDI, 32'ha04, 2'b11, 2'b00);
        tick();
        in_valid_i = 1'b0;
        repeat (3) tick();
        n_cmp++; if (perf_stall_cnt_o !== 32'd3) begin n_bad++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt_o); end
        n_cmp++; if (perf_redirect_cnt_o !== 32'd0) begin n_bad++; $display("FAIL perf_redirect: got %0d want 0", perf_redirect_cnt_o); end
`endif
        out_ready_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [6:0]  ops [8];
        logic [31:0] r;
        bundle_t     h;
        ops = '{7'h13, 7'h33, 7'h63, 7'h6f, 7'h67, 7'h03, 7'h23, 7'h37};
        for (int c = 0; c < 400; c++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < W; k++) begin
                r = $urandom;
                inst_i[k*XL +: XL] = {r[31:7], ops[$urandom_range(0, 7)]};
                r = $urandom;
                pc_i[k*XL +: XL]   = {r[31:2], 2'b00};
                slot_valid_i[k]    = ($urandom_range(0, 4) != 0);
                pred_taken_i[k]    = ($urandom_range(0, 2) == 0);
            end
            tick();
            n_cmp++; if (out_valid_o !== (mq.size() != 0)) begin n_bad++; $display("FAIL rand_out_valid c%0d: got %b want %b", c, out_valid_o, mq.size() != 0); end
            n_cmp++; if (in_ready_o !== (mq.size() < 2)) begin n_bad++; $display("FAIL rand_in_ready c%0d: got %b want %b", c, in_ready_o, mq.size() < 2); end
            n_cmp++; if (redirect_o !== m_redir) begin n_bad++; $display("FAIL rand_redirect c%0d: got %b want %b", c, redirect_o, m_redir); end
            n_cmp++; if (redirect_pc_o !== m_rpc) begin n_bad++; $display("FAIL rand_redirect_pc c%0d: got %h want %h", c, redirect_pc_o, m_rpc); end
            if (mq.size() != 0) begin
                h = mq[0];
                n_cmp++; if (inst_o !== h.inst || pc_o !== h.pc) begin n_bad++; $display("FAIL rand_inst_pc c%0d: got %h/%h want %h/%h", c, inst_o, pc_o, h.inst, h.pc); end
                n_cmp++; if (ctrl_o !== ref_ctrl_bus(h.inst)) begin n_bad++; $display("FAIL rand_ctrl c%0d: got %h want %h", c, ctrl_o, ref_ctrl_bus(h.inst)); end
                n_cmp++; if (slot_valid_o !== h.sv || pred_taken_o !== h.pt) begin n_bad++; $display("FAIL rand_flags c%0d: got sv %b pt %b want sv %b pt %b", c, slot_valid_o, pred_taken_o, h.sv, h.pt); end
            end
        end
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) tick();
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rand_final_drain: got %b want 0", out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wasnt_branch();
        test_jal_taken();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
